hazard_track_pipe: RTL and testbench
====================================

// Module: hazard_track_pipe
// PURPOSE
//   Producer side of the hazard-detection interface. Carries each instruction's hazard
//   metadata (optype, rd, rs2) down the ID->EXE->MEM->WB pipeline. Returns the
//   per-stage values that the hazard detection unit consumes: optype_before1/2,
//   rd_EXE/rd_MEM and rs2_EXE. Applies the unit's EN/flush controls to its own
//   stage registers. Keeps saturating bubble and retire counters for performance debug.
// PARAMETERS
//   CNT_W   16   width of bubble_cnt / retire_cnt
// PORTS
//   clk                         in   1      pipeline clock, all state on rising edge
//   rst                         in   1      synchronous, active-high reset
//   valid_ID                    in   1      ID stage holds a real instruction
//   hazard_optype_ID            in   2      00 none, 01 ALU, 10 load, 11 branch
//   rd_ID                       in   5      destination reg of ID instruction
//   rs2_ID                      in   5      rs2 of ID instruction
//   reg_DE_EN, reg_DE_flush     in   1,1    ID/EXE register enable / bubble request
//   reg_EM_EN, reg_EM_flush     in   1,1    EXE/MEM register enable / bubble request
//   reg_MW_EN                   in   1      MEM/WB register enable
//   cnt_clr                     in   1      synchronous clear of both counters
//   hazard_optype_ctrl_before1  out  2      optype in EXE
//   hazard_optype_ctrl_before2  out  2      optype in MEM
//   rd_EXE, rd_MEM, rd_WB       out  5 ea   rd per stage (0 when bubble)
//   rs2_EXE                     out  5      rs2 in EXE
//   valid_EXE, valid_MEM, valid_WB  out  1 ea  stage occupancy
//   bubble_cnt                  out  CNT_W  bubbles inserted into EXE
//   retire_cnt                  out  CNT_W  valid instructions that reached WB
// BEHAVIOUR
//   - Reset:
//     - all valid_* = 0; all optype/rd/rs2 outputs = 0; both counters = 0.
//     - Reset overrides every other input.
//   - All outputs are registered. Zero combinational paths from inputs to outputs.
//   - A bubble is a stage entry with valid=0, optype=00, rd=0, rs2=0.
//   - ID->EXE register, per cycle:
//     - reg_DE_flush=1: load a bubble. This holds regardless of reg_DE_EN (flush wins over hold).
//     - else reg_DE_EN=1: load {valid_ID, optype, rd, rs2}. If valid_ID=0, load a bubble.
//     - else: hold.
//   - EXE->MEM register, per cycle:
//     - reg_EM_flush=1: load a bubble. Flush wins over hold.
//     - else reg_EM_EN=1: copy the EXE stage.
//     - else: hold.
//   - MEM->WB register: reg_MW_EN=1 copies the MEM stage; else hold. It has no flush.
//   - Latency: ID values appear on the EXE outputs 1 cycle after capture.
//     They reach MEM 1 cycle later and WB 1 cycle after that, assuming all EN=1.
//   - Invariant: valid=0 implies optype=00 and rd=0. A bubble can therefore never
//     trigger a forward or a stall in the consumer.
//   - Stage holds are independent. A held downstream stage with an enabled upstream
//     stage overwrites nothing downstream. No stall-propagation logic lives here;
//     enable consistency is the hazard unit's job.
//   - bubble_cnt:
//     - +1 on every cycle where reg_DE_flush=1.
//     - +1 on every cycle where reg_DE_EN=1 and valid_ID=0.
//     - At most +1 per cycle.
//   - retire_cnt:
//     - +1 on every cycle where reg_MW_EN=1 and valid_MEM=1.
//   - Counters saturate at 2^CNT_W-1 and never wrap.
//   - cnt_clr=1 forces both counters to 0 on the next edge. This beats the
//     same-cycle increment. Pipeline state is unaffected.
//   - rst asserted mid-stream: every stage becomes a bubble on the next edge.
//     In-flight instructions are not counted as retired.
// TESTING
//   - Reset, then three back-to-back ALU ops:
//     - Stimulus: rd=5, rd=6, rd=7, all EN=1.
//     - Response: rd_EXE=5 @+1, rd_MEM=5 @+2, rd_WB=5 @+3; retire_cnt=3 @+5.
//   - Load-use:
//     - Stimulus: load rd=3 in EXE; pulse reg_DE_flush=1 with reg_DE_EN=1 for 1 cycle.
//     - Response: next cycle optype_before1=00, rd_EXE=0, optype_before2=10,
//       rd_MEM=3; bubble_cnt=1.
//   - Hold:
//     - Stimulus: reg_DE_EN=0 for 2 cycles, other EN=1.
//     - Response: rd_EXE frozen while MEM/WB drain. Then release and check that
//       order is preserved.
//   - Flush beats hold:
//     - Stimulus: reg_EM_EN=0 with reg_EM_flush=1.
//     - Response: MEM becomes a bubble (before2=00, rd_MEM=0, valid_MEM=0).
//   - Saturation and clear:
//     - Stimulus: CNT_W=3, 9 bubbles.
//     - Response: bubble_cnt=7. Then cnt_clr with a concurrent bubble gives bubble_cnt=0.
//   - Reset mid-stream:
//     - Stimulus: rst with 3 valid instructions in flight.
//     - Response: all valid_*=0 and all rd=0 next cycle; retire_cnt=0.

Source files
------------

// File: rtl/hazard_track_pipe_if.sv
// ----------------------------------------------------------------------------
// hazard_track_pipe_if
//   Bundle between the hazard detection unit / ID stage (master) and the
//   hazard metadata pipeline (slave).
//   master drives : valid_ID, hazard_optype_ID, rd_ID, rs2_ID,
//                   reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush,
//                   reg_MW_EN, cnt_clr
//   slave drives  : hazard_optype_ctrl_before1/2, rd_EXE/MEM/WB, rs2_EXE,
//                   valid_EXE/MEM/WB, bubble_cnt, retire_cnt
// ----------------------------------------------------------------------------
interface hazard_track_pipe_if #(
    parameter int CNT_W = 16
);
    logic             valid_ID;
    logic [1:0]       hazard_optype_ID;
    logic [4:0]       rd_ID;
    logic [4:0]       rs2_ID;
    logic             reg_DE_EN;
    logic             reg_DE_flush;
    logic             reg_EM_EN;
    logic             reg_EM_flush;
    logic             reg_MW_EN;
    logic             cnt_clr;

    logic [1:0]       hazard_optype_ctrl_before1;
    logic [1:0]       hazard_optype_ctrl_before2;
    logic [4:0]       rd_EXE;
    logic [4:0]       rd_MEM;
    logic [4:0]       rd_WB;
    logic [4:0]       rs2_EXE;
    logic             valid_EXE;
    logic             valid_MEM;
    logic             valid_WB;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output valid_ID, hazard_optype_ID, rd_ID, rs2_ID,
               reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN, cnt_clr,
        input  hazard_optype_ctrl_before1, hazard_optype_ctrl_before2,
               rd_EXE, rd_MEM, rd_WB, rs2_EXE,
               valid_EXE, valid_MEM, valid_WB, bubble_cnt, retire_cnt
    );

    modport slave (
        input  valid_ID, hazard_optype_ID, rd_ID, rs2_ID,
               reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN, cnt_clr,
        output hazard_optype_ctrl_before1, hazard_optype_ctrl_before2,
               rd_EXE, rd_MEM, rd_WB, rs2_EXE,
               valid_EXE, valid_MEM, valid_WB, bubble_cnt, retire_cnt
    );
endinterface

// File: rtl/hazard_track_pipe.sv
// ----------------------------------------------------------------------------
// hazard_track_pipe
//   Carries per-instruction hazard metadata (optype, rd, rs2) through the
//   ID->EXE->MEM->WB stage registers, applying the hazard unit's enable and
//   flush controls, and returns the per-stage values the hazard unit consumes.
//   Saturating counters track bubbles inserted into EXE and retired
//   instructions. All outputs come straight from registers.
// Ports
//   clk : pipeline clock, all state updates on the rising edge
//   rst : synchronous active-high reset, overrides all other inputs
//   hz  : hazard_track_pipe_if.slave (ID inputs, stage controls, counter
//         clear in; per-stage metadata, occupancy and counters out)
// ----------------------------------------------------------------------------
module hazard_track_pipe #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_track_pipe_if.slave  hz
);

    // EXE stage
    logic             r_exe_valid;
    logic [1:0]       r_exe_op;
    logic [4:0]       r_exe_rd;
    logic [4:0]       r_exe_rs2;
    // MEM stage (rs2 is only consumed in EXE, so it stops there)
    logic             r_mem_valid;
    logic [1:0]       r_mem_op;
    logic [4:0]       r_mem_rd;
    // WB stage
    logic             r_wb_valid;
    logic [4:0]       r_wb_rd;
    // counters
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_retire_cnt;

    logic             w_bubble_inc;
    logic             w_retire_inc;

    // A flush and an enabled empty ID slot in the same cycle still insert
    // only one bubble, hence the OR.
    assign w_bubble_inc = hz.reg_DE_flush | (hz.reg_DE_EN & ~hz.valid_ID);
    assign w_retire_inc = hz.reg_MW_EN & r_mem_valid;

    // ID -> EXE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exe_valid <= 1'b0;
            r_exe_op    <= '0;
            r_exe_rd    <= '0;
            r_exe_rs2   <= '0;
        end else if (hz.reg_DE_flush) begin
            r_exe_valid <= 1'b0;
            r_exe_op    <= '0;
            r_exe_rd    <= '0;
            r_exe_rs2   <= '0;
        end else if (hz.reg_DE_EN) begin
            // An empty ID slot is loaded as a clean bubble so stale fields
            // can never raise a forward or stall downstream.
            r_exe_valid <= hz.valid_ID;
            r_exe_op    <= hz.valid_ID ? hz.hazard_optype_ID : 2'b00;
            r_exe_rd    <= hz.valid_ID ? hz.rd_ID            : 5'd0;
            r_exe_rs2   <= hz.valid_ID ? hz.rs2_ID           : 5'd0;
        end
    end

    // EXE -> MEM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid <= 1'b0;
            r_mem_op    <= '0;
            r_mem_rd    <= '0;
        end else if (hz.reg_EM_flush) begin
            r_mem_valid <= 1'b0;
            r_mem_op    <= '0;
            r_mem_rd    <= '0;
        end else if (hz.reg_EM_EN) begin
            r_mem_valid <= r_exe_valid;
            r_mem_op    <= r_exe_op;
            r_mem_rd    <= r_exe_rd;
        end
    end

    // MEM -> WB (no flush path)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
        end else if (hz.reg_MW_EN) begin
            r_wb_valid <= r_mem_valid;
            r_wb_rd    <= r_mem_rd;
        end
    end

    // Saturating counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || hz.cnt_clr) begin
            r_bubble_cnt <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_bubble_inc && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            if (w_retire_inc && (r_retire_cnt != '1))
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign hz.valid_EXE                  = r_exe_valid;
    assign hz.hazard_optype_ctrl_before1 = r_exe_op;
    assign hz.rd_EXE                     = r_exe_rd;
    assign hz.rs2_EXE                    = r_exe_rs2;
    assign hz.valid_MEM                  = r_mem_valid;
    assign hz.hazard_optype_ctrl_before2 = r_mem_op;
    assign hz.rd_MEM                     = r_mem_rd;
    assign hz.valid_WB                   = r_wb_valid;
    assign hz.rd_WB                      = r_wb_rd;
    assign hz.bubble_cnt                 = r_bubble_cnt;
    assign hz.retire_cnt                 = r_retire_cnt;

endmodule

// File: tb/tb_hazard_track_pipe.sv
module tb_hazard_track_pipe;

  localparam int CW = 3;

  localparam int S_VEXE  = 0;
  localparam int S_VMEM  = 1;
  localparam int S_VWB   = 2;
  localparam int S_OP1   = 3;
  localparam int S_OP2   = 4;
  localparam int S_RDEXE = 5;
  localparam int S_RDMEM = 6;
  localparam int S_RDWB  = 7;
  localparam int S_RS2   = 8;
  localparam int S_BUB   = 9;
  localparam int S_RET   = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_track_pipe_if #(.CNT_W(CW)) hz ();

  hazard_track_pipe #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct {
    int          due;
    int          sig;
    logic [15:0] exp;
  } chk_t;

  chk_t  sb[$];
  string sig_name [11] = '{"valid_EXE", "valid_MEM", "valid_WB", "before1", "before2",
                           "rd_EXE", "rd_MEM", "rd_WB", "rs2_EXE", "bubble_cnt", "retire_cnt"};
  int    cyc     = 0;
  int    n_total = 0;
  int    n_pass  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sample(input int s);
    case (s)
      S_VEXE:  return 16'(hz.valid_EXE);
      S_VMEM:  return 16'(hz.valid_MEM);
      S_VWB:   return 16'(hz.valid_WB);
      S_OP1:   return 16'(hz.hazard_optype_ctrl_before1);
      S_OP2:   return 16'(hz.hazard_optype_ctrl_before2);
      S_RDEXE: return 16'(hz.rd_EXE);
      S_RDMEM: return 16'(hz.rd_MEM);
      S_RDWB:  return 16'(hz.rd_WB);
      S_RS2:   return 16'(hz.rs2_EXE);
      S_BUB:   return 16'(hz.bubble_cnt);
      S_RET:   return 16'(hz.retire_cnt);
      default: return 16'hdead;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [15:0] act;
    for (int unsigned i = sb.size(); i > 0; i--) begin
      if (sb[i-1].due == cyc) begin
        act = sample(sb[i-1].sig);
        n_total++;
        if (act === sb[i-1].exp)
          n_pass++;
        else
          $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                   sig_name[sb[i-1].sig], cyc, act, sb[i-1].exp);
        sb.delete(i-1);
      end
    end
  end

  // d = 0 checks the current cycle, d = 1 the state after the next edge.
  task automatic expect_at(input int d, input int s, input int v);
    chk_t c;
    c.due = cyc + d;
    c.sig = s;
    c.exp = 16'(v);
    sb.push_back(c);
  endtask

  task automatic expect_all_zero(input int d);
    for (int unsigned s = 0; s < 11; s++) expect_at(d, int'(s), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs2);
    hz.valid_ID         = v;
    hz.hazard_optype_ID = op;
    hz.rd_ID            = rd;
    hz.rs2_ID           = rs2;
  endtask

  initial begin
    rst             = 1'b1;
    issue(1'b0, 2'b00, 5'd0, 5'd0);
    hz.reg_DE_EN    = 1'b1;
    hz.reg_DE_flush = 1'b0;
    hz.reg_EM_EN    = 1'b1;
    hz.reg_EM_flush = 1'b0;
    hz.reg_MW_EN    = 1'b1;
    hz.cnt_clr      = 1'b0;
    tick();
    tick();
    expect_all_zero(0);

    rst = 1'b0;
    issue(1'b1, 2'b01, 5'd5, 5'd1);
    expect_at(1, S_VEXE, 1);  expect_at(1, S_OP1, 1); expect_at(1, S_RDEXE, 5); expect_at(1, S_RS2, 1);
    expect_at(2, S_RDMEM, 5); expect_at(2, S_OP2, 1); expect_at(2, S_VMEM, 1);
    expect_at(3, S_RDWB, 5);  expect_at(3, S_VWB, 1); expect_at(3, S_RET, 1);
    expect_at(5, S_RET, 3);
    tick();
    issue(1'b1, 2'b01, 5'd6, 5'd2);
    expect_at(1, S_RDEXE, 6); expect_at(2, S_RDMEM, 6); expect_at(3, S_RDWB, 6);
    tick();
    issue(1'b1, 2'b01, 5'd7, 5'd3);
    expect_at(1, S_RDEXE, 7); expect_at(3, S_RDWB, 7);
    tick();
    issue(1'b0, 2'b11, 5'd9, 5'd9);
    expect_at(1, S_VEXE, 0); expect_at(1, S_OP1, 0); expect_at(1, S_RDEXE, 0);
    expect_at(1, S_RS2, 0);  expect_at(1, S_BUB, 1);
    tick();
    issue(1'b0, 2'b00, 5'd0, 5'd0);
    expect_at(1, S_BUB, 2);
    tick();
    hz.cnt_clr = 1'b1;
    expect_at(1, S_BUB, 0); expect_at(1, S_RET, 0);
    tick();
    hz.cnt_clr = 1'b0;

    issue(1'b1, 2'b10, 5'd3, 5'd4);
    expect_at(1, S_OP1, 2); expect_at(1, S_RDEXE, 3);
    tick();
    issue(1'b1, 2'b01, 5'd8, 5'd3);
    hz.reg_DE_flush = 1'b1;
    expect_at(1, S_OP1, 0); expect_at(1, S_RDEXE, 0); expect_at(1, S_VEXE, 0);
    expect_at(1, S_OP2, 2); expect_at(1, S_RDMEM, 3); expect_at(1, S_BUB, 1);
    tick();
    hz.reg_DE_flush = 1'b0;
    expect_at(1, S_RDEXE, 8); expect_at(1, S_OP1, 1); expect_at(1, S_RS2, 3);
    expect_at(1, S_VMEM, 0);  expect_at(1, S_RDWB, 3); expect_at(1, S_RET, 1);
    tick();

    issue(1'b1, 2'b01, 5'd9, 5'd5);
    hz.reg_DE_EN = 1'b0;
    expect_at(1, S_RDEXE, 8); expect_at(1, S_RDMEM, 8); expect_at(1, S_RDWB, 0); expect_at(1, S_RET, 1);
    tick();
    expect_at(1, S_RDEXE, 8); expect_at(1, S_RDMEM, 8); expect_at(1, S_RDWB, 8);
    expect_at(1, S_RET, 2);   expect_at(1, S_BUB, 1);
    tick();
    hz.reg_DE_EN = 1'b1;
    expect_at(1, S_RDEXE, 9); expect_at(1, S_RS2, 5); expect_at(1, S_RDMEM, 8);
    expect_at(2, S_RDMEM, 9); expect_at(3, S_RDWB, 9); expect_at(1, S_RET, 3);
    tick();
    issue(1'b1, 2'b01, 5'd10, 5'd6);
    expect_at(1, S_RDEXE, 10); expect_at(1, S_RDMEM, 9); expect_at(1, S_RET, 4);
    tick();

    issue(1'b0, 2'b00, 5'd0, 5'd0);
    hz.reg_EM_EN    = 1'b0;
    hz.reg_EM_flush = 1'b1;
    expect_at(1, S_OP2, 0); expect_at(1, S_RDMEM, 0); expect_at(1, S_VMEM, 0);
    expect_at(1, S_VWB, 1); expect_at(1, S_RET, 5);   expect_at(1, S_BUB, 2); expect_at(1, S_VEXE, 0);
    tick();
    hz.reg_EM_EN    = 1'b1;
    hz.reg_EM_flush = 1'b0;
    hz.reg_MW_EN = 1'b0;
    expect_at(1, S_RDWB, 9); expect_at(1, S_VWB, 1); expect_at(1, S_RET, 5); expect_at(1, S_BUB, 3);
    tick();
    hz.reg_MW_EN = 1'b1;

    hz.cnt_clr = 1'b1;
    expect_at(1, S_BUB, 0); expect_at(1, S_RET, 0);
    tick();
    hz.cnt_clr = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      expect_at(1, S_BUB, int'(k));
      tick();
    end
    hz.reg_DE_flush = 1'b1;
    expect_at(1, S_BUB, 5);
    tick();
    hz.reg_DE_EN = 1'b0;
    expect_at(1, S_BUB, 6);
    tick();
    issue(1'b1, 2'b01, 5'd4, 5'd4);
    expect_at(1, S_BUB, 7); expect_at(1, S_VEXE, 0);
    tick();
    hz.reg_DE_flush = 1'b0;
    hz.reg_DE_EN    = 1'b1;
    issue(1'b0, 2'b00, 5'd0, 5'd0);
    expect_at(1, S_BUB, 7);
    tick();
    expect_at(1, S_BUB, 7);
    tick();
    hz.cnt_clr = 1'b1;
    expect_at(1, S_BUB, 0);
    tick();
    hz.cnt_clr = 1'b0;
    expect_at(1, S_BUB, 1);
    tick();

    issue(1'b1, 2'b01, 5'd11, 5'd1);
    tick();
    issue(1'b1, 2'b01, 5'd12, 5'd2);
    tick();
    issue(1'b1, 2'b10, 5'd13, 5'd3);
    tick();
    expect_at(0, S_RDWB, 11); expect_at(0, S_RDMEM, 12); expect_at(0, S_RDEXE, 13);
    expect_at(0, S_RET, 1);   expect_at(0, S_VWB, 1);
    rst = 1'b1;
    issue(1'b1, 2'b01, 5'd14, 5'd4);
    expect_all_zero(1);
    tick();

    n_total++;
    if (hz.valid_EXE === 1'b0) n_pass++;
    else $display("FAIL direct valid_EXE after reset: got %0d", hz.valid_EXE);
    n_total++;
    if (hz.rd_EXE === 5'd0) n_pass++;
    else $display("FAIL direct rd_EXE after reset: got %0d", hz.rd_EXE);
    n_total++;
    if ((hz.rd_MEM | hz.rd_WB) === 5'd0) n_pass++;
    else $display("FAIL direct rd_MEM/rd_WB after reset: got %0d/%0d", hz.rd_MEM, hz.rd_WB);
    n_total++;
    if (hz.retire_cnt === '0) n_pass++;
    else $display("FAIL direct retire_cnt after reset: got %0d", hz.retire_cnt);

    rst = 1'b0;
    issue(1'b0, 2'b00, 5'd0, 5'd0);
    tick();
    tick();
    @(negedge clk);
    #1;

    foreach (sb[i]) begin
      n_total++;
      $display("FAIL %s: check due at cyc %0d never sampled, expected %0d",
               sig_name[sb[i].sig], sb[i].due, sb[i].exp);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
